// File: rtl/fire_sensor_conditioner.sv
// Flame-sensor front end: 2-FF synchroniser, bidirectional debounce, minimum
// alarm hold time, one-cycle fire/clear event pulses and a saturating event count.
module fire_sensor_conditioner #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 200_000_000,
    parameter bit ACTIVE_LOW_IN   = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sensor_in,
    output logic       fire_detect,
    output logic       fire_pulse,
    output logic       clear_pulse,
    output logic [7:0] fire_count,
    output logic [1:0] state
);

    // The hold counter must be able to hold HOLD_CYCLES itself, hence the +1.
    localparam int CNT_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_SAFE   = 2'd0,
        ST_ARM    = 2'd1,
        ST_FIRE   = 2'd2,
        ST_DISARM = 2'd3
    } state_t;

    state_t              r_state;
    logic                r_sync1;
    logic                r_sync2;
    logic [CNT_W-1:0]    r_cnt;
    logic [HOLD_W-1:0]   r_hold;
    logic                r_fire_detect;
    logic                r_fire_pulse;
    logic                r_clear_pulse;
    logic [7:0]          r_fire_count;
    logic                w_p;

    assign w_p = sensor_in ^ ACTIVE_LOW_IN;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_SAFE;
            r_sync1       <= 1'b0;
            r_sync2       <= 1'b0;
            r_cnt         <= '0;
            r_hold        <= '0;
            r_fire_detect <= 1'b0;
            r_fire_pulse  <= 1'b0;
            r_clear_pulse <= 1'b0;
            r_fire_count  <= 8'd0;
        end else begin
            r_sync1       <= w_p;
            r_sync2       <= r_sync1;
            r_fire_pulse  <= 1'b0;
            r_clear_pulse <= 1'b0;
            case (r_state)
                ST_SAFE: begin
                    if (r_sync2) begin
                        r_state <= ST_ARM;
                        r_cnt   <= '0;
                    end
                end
                ST_ARM: begin
                    if (!r_sync2) begin
                        r_state <= ST_SAFE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= ST_FIRE;
                        r_hold        <= HOLD_INIT;
                        r_fire_detect <= 1'b1;
                        r_fire_pulse  <= 1'b1;
                        if (r_fire_count != 8'd255) begin
                            r_fire_count <= r_fire_count + 8'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                // The sensor is ignored until the hold time has fully elapsed.
                ST_FIRE: begin
                    if (r_hold != '0) begin
                        r_hold <= r_hold - HOLD_W'(1);
                    end else if (!r_sync2) begin
                        r_state <= ST_DISARM;
                        r_cnt   <= '0;
                    end
                end
                ST_DISARM: begin
                    if (r_sync2) begin
                        r_state <= ST_FIRE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state       <= ST_SAFE;
                        r_fire_detect <= 1'b0;
                        r_clear_pulse <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= ST_SAFE;
            endcase
        end
    end

    assign fire_detect = r_fire_detect;
    assign fire_pulse  = r_fire_pulse;
    assign clear_pulse = r_clear_pulse;
    assign fire_count  = r_fire_count;
    assign state       = r_state;

endmodule

// File: tb/tb_fire_sensor_conditioner.sv
// Bench for fire_sensor_conditioner: directed scenarios plus randomized sensor
// traffic compared against a run-length reference model of the alarm rules.
module tb_fire_sensor_conditioner;

    localparam int D = 4;
    localparam int H = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sensor_in;
    logic       sensor_al;
    logic       fire_detect, fire_pulse, clear_pulse;
    logic [7:0] fire_count;
    logic [1:0] state;
    logic       fire_detect_al, fire_pulse_al, clear_pulse_al;
    logic [7:0] fire_count_al;
    logic [1:0] state_al;

    int n_tests = 0;
    int n_fail  = 0;

    fire_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .ACTIVE_LOW_IN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .sensor_in(sensor_in),
        .fire_detect(fire_detect), .fire_pulse(fire_pulse), .clear_pulse(clear_pulse),
        .fire_count(fire_count), .state(state)
    );

    fire_sensor_conditioner #(.DEBOUNCE_CYCLES(D), .HOLD_CYCLES(H), .ACTIVE_LOW_IN(1'b1)) dut_al (
        .clk(clk), .rst_n(rst_n), .sensor_in(sensor_al),
        .fire_detect(fire_detect_al), .fire_pulse(fire_pulse_al), .clear_pulse(clear_pulse_al),
        .fire_count(fire_count_al), .state(state_al)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Alarm rules as run lengths of the synchronised level: an alarm starts after
    // D+1 consecutive high samples; once raised it lasts H edges regardless of the
    // input, then ends after D+1 consecutive low samples.
    logic m_sync1, m_s, m_det, m_fp, m_cp;
    int   m_run, m_age, m_cnt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_sync1 = 1'b0; m_s = 1'b0; m_det = 1'b0; m_fp = 1'b0; m_cp = 1'b0;
            m_run = 0; m_age = 0; m_cnt = 0;
        end else begin
            m_fp = 1'b0;
            m_cp = 1'b0;
            if (!m_det) begin
                m_run = m_s ? m_run + 1 : 0;
                if (m_run == D + 1) begin
                    m_det = 1'b1; m_fp = 1'b1; m_age = 0; m_run = 0;
                    if (m_cnt < 255) m_cnt = m_cnt + 1;
                end
            end else begin
                m_age = m_age + 1;
                if (m_age > H) begin
                    m_run = m_s ? 0 : m_run + 1;
                    if (m_run == D + 1) begin
                        m_det = 1'b0; m_cp = 1'b1; m_run = 0;
                    end
                end
            end
            m_s     = m_sync1;
            m_sync1 = sensor_in;
        end
    end

    function automatic logic [1:0] m_state();
        if (!m_det) return (m_run == 0) ? 2'd0 : 2'd1;
        return (m_age <= H || m_run == 0) ? 2'd2 : 2'd3;
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 8; i++) begin
            sensor_in = 1'($urandom_range(0, 1));
            sensor_al = 1'($urandom_range(0, 1));
            @(negedge clk);
            n_tests++;
            if ({fire_detect, fire_pulse, clear_pulse, fire_count, state} !== 13'd0) begin
                n_fail++;
                $display("FAIL reset: fd=%b fp=%b cp=%b cnt=%0d st=%0d, required all 0",
                         fire_detect, fire_pulse, clear_pulse, fire_count, state);
            end
        end
        sensor_in = 1'b0;
        sensor_al = 1'b1;
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_glitch();
        for (int i = 0; i < 15; i++) begin
            sensor_in = (i < 3);
            @(negedge clk);
            n_tests++;
            if (fire_detect !== 1'b0 || fire_pulse !== 1'b0 || state !== m_state()) begin
                n_fail++;
                $display("FAIL glitch cyc%0d: fd=%b fp=%b st=%0d, required fd=0 fp=0 st=%0d",
                         i, fire_detect, fire_pulse, state, m_state());
            end
        end
        n_tests++;
        if (state !== 2'd0 || fire_count !== 8'd0) begin
            n_fail++;
            $display("FAIL glitch_end: st=%0d cnt=%0d, required st=0 cnt=0", state, fire_count);
        end
    endtask

    task automatic test_clean_fire();
        for (int k = 1; k <= 20; k++) begin
            sensor_in = 1'b1;
            @(negedge clk);
            n_tests++;
            if (fire_detect !== (k >= 7) || fire_pulse !== (k == 7) || state !== m_state()) begin
                n_fail++;
                $display("FAIL clean_fire edge%0d: fd=%b fp=%b st=%0d, required fd=%b fp=%b st=%0d",
                         k, fire_detect, fire_pulse, state, k >= 7, k == 7, m_state());
            end
        end
        n_tests++;
        if (fire_count !== 8'd1) begin
            n_fail++;
            $display("FAIL clean_fire_count: cnt=%0d, required 1", fire_count);
        end
        for (int k = 1; k <= 10; k++) begin
            sensor_in = 1'b0;
            @(negedge clk);
            n_tests++;
            if (fire_detect !== (k < 7) || clear_pulse !== (k == 7)) begin
                n_fail++;
                $display("FAIL clear_latency edge%0d: fd=%b cp=%b, required fd=%b cp=%b",
                         k, fire_detect, clear_pulse, k < 7, k == 7);
            end
        end
    endtask

    task automatic test_short_fire_hold();
        int hi = 0, n_cp = 0, n_fire = 0, n_dis = 0;
        for (int k = 1; k <= 30; k++) begin
            sensor_in = (k <= 15);
            @(negedge clk);
            hi     += int'(fire_detect);
            n_cp   += int'(clear_pulse);
            n_fire += int'(state == 2'd2);
            n_dis  += int'(state == 2'd3);
            n_tests++;
            if (fire_detect !== m_det || clear_pulse !== m_cp) begin
                n_fail++;
                $display("FAIL short_fire edge%0d: fd=%b cp=%b, required fd=%b cp=%b",
                         k, fire_detect, clear_pulse, m_det, m_cp);
            end
        end
        n_tests++;
        if (hi != H + 1 + D || n_fire != H + 1 || n_dis != D || n_cp != 1) begin
            n_fail++;
            $display("FAIL hold_width: high=%0d fire=%0d disarm=%0d clears=%0d, required %0d %0d %0d 1",
                     hi, n_fire, n_dis, n_cp, H + 1 + D, H + 1, D);
        end
    endtask

    task automatic test_chatter();
        int   fp_total = 0;
        logic saw_dis  = 1'b0;
        int   cnt_exp  = m_cnt + 1;
        for (int k = 1; k <= 40; k++) begin
            sensor_in = !(k == 26 || k == 27);
            @(negedge clk);
            fp_total += int'(fire_pulse);
            if (state == 2'd3) saw_dis = 1'b1;
            n_tests++;
            if (fire_detect !== (k >= 7)) begin
                n_fail++;
                $display("FAIL chatter_fd edge%0d: fd=%b, required %b", k, fire_detect, k >= 7);
            end
        end
        n_tests++;
        if (!saw_dis || state !== 2'd2 || fp_total != 1 || fire_count !== 8'(cnt_exp)) begin
            n_fail++;
            $display("FAIL chatter_end: saw_disarm=%b st=%0d pulses=%0d cnt=%0d, required 1 2 1 %0d",
                     saw_dis, state, fp_total, fire_count, cnt_exp);
        end
        sensor_in = 1'b0;
        repeat (12) @(negedge clk);
        n_tests++;
        if (state !== 2'd0 || fire_detect !== 1'b0) begin
            n_fail++;
            $display("FAIL chatter_clear: st=%0d fd=%b, required 0 0", state, fire_detect);
        end
    endtask

    task automatic test_random();
        for (int seg = 0; seg < 50; seg++) begin
            logic lvl = 1'($urandom_range(0, 1));
            int   len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) begin
                sensor_in = lvl;
                @(negedge clk);
                n_tests++;
                if ({fire_detect, fire_pulse, clear_pulse, fire_count, state} !==
                    {m_det, m_fp, m_cp, 8'(m_cnt), m_state()}) begin
                    n_fail++;
                    $display("FAIL random seg%0d: fd=%b fp=%b cp=%b cnt=%0d st=%0d, required %b %b %b %0d %0d",
                             seg, fire_detect, fire_pulse, clear_pulse, fire_count, state,
                             m_det, m_fp, m_cp, m_cnt, m_state());
                end
            end
        end
        sensor_in = 1'b0;
        repeat (30) @(negedge clk);
        n_tests++;
        if (state !== 2'd0 || fire_count !== 8'(m_cnt)) begin
            n_fail++;
            $display("FAIL random_drain: st=%0d cnt=%0d, required 0 %0d", state, fire_count, m_cnt);
        end
    endtask

    task automatic test_saturation();
        for (int ev = 0; ev < 260; ev++) begin
            int fp_seen = 0, cp_seen = 0;
            for (int k = 0; k < 8; k++) begin
                sensor_in = 1'b1;
                @(negedge clk);
                fp_seen += int'(fire_pulse);
            end
            for (int k = 0; k < 16; k++) begin
                sensor_in = 1'b0;
                @(negedge clk);
                cp_seen += int'(clear_pulse);
            end
            n_tests++;
            if (fp_seen != 1 || cp_seen != 1) begin
                n_fail++;
                $display("FAIL sat_event%0d: fire_pulses=%0d clear_pulses=%0d, required 1 1",
                         ev, fp_seen, cp_seen);
            end
        end
        n_tests++;
        if (fire_count !== 8'd255) begin
            n_fail++;
            $display("FAIL saturation: cnt=%0d, required 255", fire_count);
        end
    endtask

    task automatic test_async_reset();
        sensor_in = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL pre_reset_arm: st=%0d, required 1", state);
        end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({fire_detect, fire_pulse, clear_pulse, fire_count, state} !== 13'd0 ||
            {fire_detect_al, fire_count_al, state_al} !== 11'd0) begin
            n_fail++;
            $display("FAIL async_reset: fd=%b fp=%b cp=%b cnt=%0d st=%0d, required all 0",
                     fire_detect, fire_pulse, clear_pulse, fire_count, state);
        end
        @(negedge clk);
        sensor_in = 1'b0;
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_active_low();
        for (int k = 1; k <= 10; k++) begin
            sensor_al = 1'b0;
            @(negedge clk);
            n_tests++;
            if (fire_detect_al !== (k >= 7) || fire_pulse_al !== (k == 7)) begin
                n_fail++;
                $display("FAIL active_low edge%0d: fd=%b fp=%b, required fd=%b fp=%b",
                         k, fire_detect_al, fire_pulse_al, k >= 7, k == 7);
            end
        end
        n_tests++;
        if (fire_count_al !== 8'd1) begin
            n_fail++;
            $display("FAIL active_low_count: cnt=%0d, required 1", fire_count_al);
        end
        sensor_al = 1'b1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n     = 1'b0;
        sensor_in = 1'b0;
        sensor_al = 1'b1;
        test_reset();
        test_glitch();
        test_clean_fire();
        test_short_fire_hold();
        test_chatter();
        test_random();
        test_saturation();
        test_async_reset();
        test_active_low();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/fire_sensor_conditioner.md
# fire_sensor_conditioner

Conditions the raw flame-sensor pin before it reaches the FIRE/SAFE seven-segment display top, replacing the direct use of the unfiltered pin. Synchronises the asynchronous input and debounces it in both directions. Enforces a minimum alarm hold time and emits one-cycle event pulses plus a saturating event counter. The clean `fire_detect` output drives the display top's `sensor_in`.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive stable synchronised cycles required to change state (10 ms at 100 MHz); legal range ≥1.
- `HOLD_CYCLES`, 200_000_000: minimum cycles `fire_detect` stays high after assertion (2 s at 100 MHz); legal range ≥0.
- `ACTIVE_LOW_IN`, 0: 1 = sensor pin is low when fire is present; the pin is inverted before the synchroniser.
- Counter widths are derived with `$clog2` of the respective parameter (minimum 1 bit).

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `sensor_in`  in  1  raw sensor pin, asynchronous to `clk`.
- `fire_detect`  out  1  debounced, hold-extended fire flag.
- `fire_pulse`  out  1  one-cycle pulse on each SAFE→fire transition.
- `clear_pulse`  out  1  one-cycle pulse on each return to SAFE.
- `fire_count`  out  8  number of fire events, saturating at 255.
- `state`  out  2  current FSM state (debug).

## Operation
- Input path: `p = sensor_in ^ ACTIVE_LOW_IN`, followed by a 2-FF synchroniser. Its second stage `s` is the only signal the FSM samples.
- A single debounce counter `cnt` is shared by ARM and DISARM. It is cleared on entry to either state.
- A separate hold counter `hold` is used only in FIRE.

FSM encoding: SAFE=0, ARM=1, FIRE=2, DISARM=3.
- SAFE: if `s=1`, go to ARM with `cnt←0`.
- ARM:
  - `s=0`: return to SAFE. No pulse, no count.
  - `s=1` and `cnt==DEBOUNCE_CYCLES-1`: go to FIRE with `hold←HOLD_CYCLES`, `fire_pulse←1`, and `fire_count←fire_count+1` unless it is already 255.
  - Otherwise `cnt++`.
- FIRE:
  - If `hold≠0`, then `hold--`.
  - If `hold==0` and `s=0`, go to DISARM with `cnt←0`.
  - While `hold≠0`, `s` is ignored.
- DISARM:
  - `s=1`: return to FIRE with `hold` left at 0. No `fire_pulse`, no count.
  - `s=0` and `cnt==DEBOUNCE_CYCLES-1`: go to SAFE with `clear_pulse←1`.
  - Otherwise `cnt++`.

Outputs:
- `fire_detect` is 1 in FIRE and DISARM and 0 in SAFE and ARM. It is registered, not decoded combinationally.
- `fire_pulse` and `clear_pulse` are registered. Each is high for exactly one cycle, coincident with the first cycle of the new state.
- `fire_count` never wraps.
- Reset (asynchronous, any state, mid-count included) clears all of the following: synchroniser flops, `cnt`, `hold`, `state→SAFE`, `fire_detect`, `fire_pulse`, `clear_pulse`, `fire_count`. The first state evaluation happens on the first `clk` edge after `rst_n` deasserts.

## Timing
- Reset values: `fire_detect`=0, `fire_pulse`=0, `clear_pulse`=0, `fire_count`=0, `state`=0.
- Assertion latency: `p` rises before edge 1 and stays high. Edge 1 loads sync1, edge 2 loads `s`, edge 3 enters ARM. `fire_detect` and `fire_pulse` are high after edge `DEBOUNCE_CYCLES+3`.
- Deassertion latency, hold already expired: `p` falls before edge 1. DISARM is entered at edge 3. `fire_detect` falls and `clear_pulse` is high after edge `DEBOUNCE_CYCLES+3`.
- Minimum alarm width: `fire_detect` stays high for at least `HOLD_CYCLES+1+DEBOUNCE_CYCLES` cycles.
- `HOLD_CYCLES=0` means the hold check passes on the first FIRE cycle.
- Glitch rejection: any `p` pulse that yields fewer than `DEBOUNCE_CYCLES+1` consecutive `s=1` cycles produces no event.
- A `p` toggle within a single cycle may be missed. This is acceptable.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=10`, `ACTIVE_LOW_IN=0` unless stated.
- Reset: hold `rst_n=0` with `sensor_in` toggling → all outputs 0 and `state=0` throughout.
- Clean fire: `sensor_in` goes high and stays high → `fire_detect` and `fire_pulse` rise after edge 7; `fire_pulse` is low after edge 8; `fire_count`=1.
- Glitch: `sensor_in` high for 3 cycles, then low → `fire_detect` never rises; `state` returns to 0; `fire_count`=0.
- Short fire with hold: `sensor_in` high for 8 cycles past assertion, then low → `fire_detect` stays high until hold expires (11 FIRE cycles), then 4 DISARM cycles; `clear_pulse` pulses once as `fire_detect` falls.
- Chatter in DISARM: after hold expiry, `sensor_in` low for 2 cycles, then high → `state` returns to 2; `fire_detect` never drops; no `fire_pulse`; `fire_count` unchanged.
- Saturation and async reset: 260 clean fire/clear cycles → `fire_count`=255, with `fire_pulse` still occurring each event. Then `rst_n` is pulsed low mid-ARM → all outputs 0 immediately, without waiting for a `clk` edge. Repeat the clean-fire case with `ACTIVE_LOW_IN=1` and the pin driven low → same timing as the clean-fire case.
